// File: rtl/program_loader.sv
// Framed byte-stream bootloader: assembles big-endian words, writes them to program memory,
// holds the CPU in reset during a load and checks a trailing XOR checksum.
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic        prog_write,
    output logic [7:0]  prog_addr,
    output logic [31:0] prog_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle, StBase, StCount, StData, StWrite, StChk, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  words_q, words_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  paddr_q, paddr_d;
    logic [31:0] pdata_q, pdata_d;
    logic        error_q, error_d;

    logic ready_st;
    logic accept;
    logic tmo_run;

    // Ready is forced low while clr is asserted, independent of the state register.
    assign rx_ready  = ready_st & ~clr;
    assign accept    = rx_valid & rx_ready;
    assign prog_addr = paddr_q;
    assign prog_data = pdata_q;
    assign error     = error_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        idx_d      = idx_q;
        data_d     = data_q;
        chk_d      = chk_q;
        tmo_d      = '0;
        paddr_d    = paddr_q;
        pdata_d    = pdata_q;
        error_d    = error_q;
        ready_st   = 1'b0;
        prog_write = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        tmo_run    = 1'b0;

        case (state_q)
            StIdle: begin
                ready_st = 1'b1;
                if (accept && rx_byte == SYNC_BYTE) begin
                    state_d = StBase;
                    error_d = 1'b0;
                    chk_d   = '0;
                end
            end
            StBase: begin
                ready_st = 1'b1;
                cpu_hold = 1'b1;
                tmo_run  = ~accept;
                if (accept) begin
                    addr_d  = rx_byte;
                    state_d = StCount;
                end
            end
            StCount: begin
                ready_st = 1'b1;
                cpu_hold = 1'b1;
                tmo_run  = ~accept;
                if (accept) begin
                    words_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                ready_st = 1'b1;
                cpu_hold = 1'b1;
                tmo_run  = ~accept;
                if (accept) begin
                    data_d = {data_q[23:0], rx_byte};
                    chk_d  = chk_q ^ rx_byte;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StWrite;
                        paddr_d = addr_q;
                        pdata_d = {data_q[23:0], rx_byte};
                    end
                end
            end
            StWrite: begin
                cpu_hold   = 1'b1;
                prog_write = 1'b1;
                addr_d     = addr_q + 8'd1;
                words_d    = words_q - 9'd1;
                state_d    = (words_q == 9'd1) ? StChk : StData;
            end
            StChk: begin
                ready_st = 1'b1;
                cpu_hold = 1'b1;
                tmo_run  = ~accept;
                if (accept) begin
                    state_d = (rx_byte == chk_q) ? StDone : StErr;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Idle counter only advances on stalled cycles; accepts and state changes restart it.
        if (tmo_run) begin
            if (tmo_q == 16'(TIMEOUT - 1)) begin
                state_d = StErr;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        if (state_d == StErr) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            addr_q  <= '0;
            words_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            paddr_q <= '0;
            pdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, wrap, 256-word, timeout, async reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        clr;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        prog_write;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt = 0;
    logic [31:0] frame_words [256];

    program_loader #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .prog_write (prog_write),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_write === 1'b1) begin
            wr_addr.push_back(prog_addr);
            wr_data.push_back(prog_data);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_valid = 1'b1;
        rx_byte  = b;
        w = 0;
        while (rx_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_stall: rx_ready=%b after %0d cycles, required 1", rx_ready, w);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] base, input int n, input bit force_chk,
                             input logic [7:0] forced);
        logic [7:0] chk;
        logic [31:0] w;
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            chk = chk ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        n_cmp++;
        if (cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: cpu_hold=%b required 0", cpu_hold);
        end
        send_byte(8'hA5);
        n_cmp++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_after_sync: cpu_hold=%b required 1", cpu_hold);
        end
        n_cmp++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL error_clear_on_sync: error=%b required 0", error);
        end
        send_byte(base);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(force_chk ? forced : chk);
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input logic [7:0] base, input int n, input string name);
        logic [7:0] ea;
        n_cmp++;
        if (wr_addr.size() != n) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            ea = base + 8'(i);
            n_cmp++;
            if (wr_addr[i] !== ea || wr_data[i] !== frame_words[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got %h/%h required %h/%h", name, i,
                         wr_addr[i], wr_data[i], ea, frame_words[i]);
            end
        end
    endtask

    task automatic test_reset();
        clr      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #2;
        n_cmp++;
        if ({rx_ready, prog_write, prog_addr, prog_data, cpu_hold, done, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b wr=%b a=%h d=%h hold=%b done=%b err=%b",
                     rx_ready, prog_write, prog_addr, prog_data, cpu_hold, done, error);
        end
        repeat (2) @(negedge clk);
        clr = 1'b0;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: rx_ready=%b required 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int d0;
        wr_addr.delete();
        wr_data.delete();
        d0 = done_cnt;
        frame_words[0] = 32'h24080005;
        frame_words[1] = 32'h8C090000;
        run_frame(8'h10, 2, 1'b0, 8'h00);
        n_cmp++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_done_state: done=%b hold=%b err=%b required 1/0/0",
                     done, cpu_hold, error);
        end
        n_cmp++;
        if (prog_addr !== 8'h11 || prog_data !== 32'h8C090000) begin
            n_fail++;
            $display("FAIL nominal_hold_regs: got %h/%h required 11/8c090000",
                     prog_addr, prog_data);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_idle_after: done=%b rdy=%b required 0/1", done, rx_ready);
        end
        check_writes(8'h10, 2, "nominal");
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL nominal_done_pulses: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_bad_checksum();
        int d0;
        wr_addr.delete();
        wr_data.delete();
        d0 = done_cnt;
        run_frame(8'h10, 2, 1'b1, 8'h00);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL badchk_err_state: err=%b done=%b hold=%b rdy=%b required 1/0/0/0",
                     error, done, cpu_hold, rx_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL badchk_sticky: error=%b required 1", error);
        end
        check_writes(8'h10, 2, "badchk");
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL badchk_done_pulses: got %0d required 0", done_cnt - d0);
        end
    endtask

    task automatic test_addr_wrap();
        wr_addr.delete();
        wr_data.delete();
        frame_words[0] = 32'hDEADBEEF;
        frame_words[1] = 32'h01234567;
        run_frame(8'hFF, 2, 1'b0, 8'h00);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: done=%b err=%b required 1/0", done, error);
        end
        @(negedge clk);
        check_writes(8'hFF, 2, "wrap");
    endtask

    task automatic test_count_256();
        int d0;
        wr_addr.delete();
        wr_data.delete();
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            frame_words[i] = {8'(i), 8'(i) ^ 8'h5A, 8'(255 - i), 8'h3C};
        end
        run_frame(8'h40, 256, 1'b0, 8'h00);
        @(negedge clk);
        check_writes(8'h40, 256, "count256");
        n_cmp++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL count256_done: pulses=%0d err=%b required 1/0", done_cnt - d0, error);
        end
    endtask

    task automatic test_timeout();
        int k;
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        k = 0;
        while (error !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL timeout_cycles: error after %0d cycles, required 16", k);
        end
        @(negedge clk);
        n_cmp++;
        if (rx_ready !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_idle: rdy=%b hold=%b err=%b required 1/0/1",
                     rx_ready, cpu_hold, error);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        rx_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b1 || cpu_hold !== 1'b0 || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_junk: err=%b hold=%b writes=%0d required 1/0/0",
                     error, cpu_hold, wr_addr.size());
        end
    endtask

    task automatic test_async_reset();
        int d0;
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        rx_byte = 8'hDD;
        @(posedge clk);
        #1;
        n_cmp++;
        if (prog_write !== 1'b1 || prog_addr !== 8'h10 || prog_data !== 32'hAABBCCDD) begin
            n_fail++;
            $display("FAIL areset_write_cycle: wr=%b a=%h d=%h required 1/10/aabbccdd",
                     prog_write, prog_addr, prog_data);
        end
        #1;
        clr = 1'b1;
        #1;
        rx_valid = 1'b0;
        n_cmp++;
        if ({rx_ready, prog_write, prog_addr, prog_data, cpu_hold, done, error} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs: rdy=%b wr=%b a=%h d=%h hold=%b done=%b err=%b",
                     rx_ready, prog_write, prog_addr, prog_data, cpu_hold, done, error);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL areset_no_strobe: writes=%0d required 0", wr_addr.size());
        end
        d0 = done_cnt;
        frame_words[0] = 32'h24080005;
        frame_words[1] = 32'h8C090000;
        run_frame(8'h10, 2, 1'b0, 8'h00);
        @(negedge clk);
        check_writes(8'h10, 2, "areset_reload");
        n_cmp++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_reload_done: pulses=%0d err=%b required 1/0",
                     done_cnt - d0, error);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_addr_wrap();
        test_count_256();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
